// File: rtl/spi_flash_resp.sv
// SPI mode-0 responder emulating one serial flash drive: command/address/data decode,
// byte array for READ/PROGRAM, and WREN/WRDI/RDSR status handling. SPI pins are oversampled in clk.
module spi_flash_resp #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned PAGE_W   = 4,
   parameter int unsigned PROG_CYC = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic spi_clk,
   input  logic spi_cs,
   input  logic spi_mosi,
   output logic spi_miso,
   output logic wip,
   output logic wel,
   output logic cmd_err
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = $clog2(PROG_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_RD,
      S_WR,
      S_STAT,
      S_IGNORE
   } state_t;

   state_t              state;
   logic [2:0]          sclk_q;
   logic [2:0]          cs_q;
   logic [1:0]          mosi_q;
   logic [2:0]          bit_cnt;
   logic [6:0]          sh_in;
   logic [7:0]          sh_out;
   logic [7:0]          wr_data;
   logic [ADDR_W-1:0]   addr;
   logic                addr_hi;
   logic                is_write;
   logic                wrote;
   logic                wr_pend;
   logic [1:0]          wel_act;
   logic [CNT_W-1:0]    prog_cnt;

   // Stored inverted so the power-up all-zero array reads back as erased (0xFF).
   logic [7:0]          mem_n [DEPTH];

   logic                rise, fall, cs_fall, cs_rise, byte_done;
   logic [7:0]          rx_byte, rd_byte, status;
   state_t              dec_state;
   logic                dec_err, dec_write;
   logic [1:0]          dec_wel;
   logic                wel_set_now, wel_clr_now, prog_now;

   assign rise      = sclk_q[1] & ~sclk_q[2];
   assign fall      = ~sclk_q[1] & sclk_q[2];
   assign cs_fall   = ~cs_q[1] & cs_q[2];
   assign cs_rise   = cs_q[1] & ~cs_q[2];
   assign rx_byte   = {sh_in, mosi_q[1]};
   assign byte_done = rise && (bit_cnt == 3'd7) && (state != S_IDLE);
   assign rd_byte   = ~mem_n[addr];
   assign status    = {6'b0, wel, wip};

   always_comb begin
      dec_state = S_IGNORE;
      dec_err   = 1'b1;
      dec_write = 1'b0;
      dec_wel   = 2'b00;
      if (rx_byte == 8'h05) begin
         dec_state = S_STAT;
         dec_err   = 1'b0;
      end else if (!wip) begin
         case (rx_byte)
            8'h06: begin dec_err = 1'b0; dec_wel = 2'b10; end
            8'h04: begin dec_err = 1'b0; dec_wel = 2'b01; end
            8'h03: begin dec_state = S_ADDR; dec_err = 1'b0; end
            8'h02: begin
               if (wel) begin
                  dec_state = S_ADDR;
                  dec_err   = 1'b0;
                  dec_write = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // A cs rise may coincide with the final rise of a byte; decide its side effects from both.
   assign wel_set_now = (state == S_IGNORE && wel_act[1]) ||
                        (state == S_CMD && byte_done && dec_wel[1]);
   assign wel_clr_now = (state == S_IGNORE && wel_act[0]) ||
                        (state == S_CMD && byte_done && dec_wel[0]);
   assign prog_now    = (state == S_WR) && (wrote || byte_done);

   always_ff @(posedge clk) begin
      if (wr_pend) mem_n[addr] <= ~wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         sclk_q   <= '0;
         cs_q     <= '1;
         mosi_q   <= '0;
         bit_cnt  <= '0;
         sh_in    <= '0;
         sh_out   <= '0;
         wr_data  <= '0;
         addr     <= '0;
         addr_hi  <= 1'b0;
         is_write <= 1'b0;
         wrote    <= 1'b0;
         wr_pend  <= 1'b0;
         wel_act  <= '0;
         prog_cnt <= '0;
         spi_miso <= 1'b0;
         wip      <= 1'b0;
         wel      <= 1'b0;
         cmd_err  <= 1'b0;
      end else begin
         sclk_q  <= {sclk_q[1:0], spi_clk};
         cs_q    <= {cs_q[1:0], spi_cs};
         mosi_q  <= {mosi_q[0], spi_mosi};
         cmd_err <= 1'b0;
         wr_pend <= 1'b0;

         if (wr_pend) addr[PAGE_W-1:0] <= addr[PAGE_W-1:0] + PAGE_W'(1);

         if (wip) begin
            prog_cnt <= prog_cnt - CNT_W'(1);
            if (prog_cnt <= CNT_W'(1)) wip <= 1'b0;
         end

         if (rise && state != S_IDLE) begin
            sh_in   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            case (state)
               S_CMD: begin
                  if (bit_cnt == 3'd7) begin
                     state    <= dec_state;
                     cmd_err  <= dec_err;
                     wel_act  <= dec_wel;
                     is_write <= dec_write;
                  end
               end
               S_ADDR: begin
                  addr <= {addr[ADDR_W-2:0], mosi_q[1]};
                  if (bit_cnt == 3'd7) begin
                     addr_hi <= 1'b1;
                     if (addr_hi) state <= is_write ? S_WR : S_RD;
                  end
               end
               S_WR: begin
                  if (bit_cnt == 3'd7) begin
                     wr_pend <= 1'b1;
                     wr_data <= rx_byte;
                     wrote   <= 1'b1;
                  end
               end
               default: ;
            endcase
         end

         // Falls with bit_cnt==0 sit between bytes: load the next outgoing byte there.
         if (fall && (state == S_RD || state == S_STAT)) begin
            if (bit_cnt == 3'd0) begin
               if (state == S_RD) begin
                  sh_out   <= {rd_byte[6:0], 1'b0};
                  spi_miso <= rd_byte[7];
                  addr     <= addr + ADDR_W'(1);
               end else begin
                  sh_out   <= {status[6:0], 1'b0};
                  spi_miso <= status[7];
               end
            end else begin
               sh_out   <= {sh_out[6:0], 1'b0};
               spi_miso <= sh_out[7];
            end
         end

         if (cs_q[1]) begin
            if (cs_rise) begin
               if (prog_now) begin
                  wel      <= 1'b0;
                  wip      <= 1'b1;
                  prog_cnt <= CNT_W'(PROG_CYC);
               end else if (wel_set_now) begin
                  wel <= 1'b1;
               end else if (wel_clr_now) begin
                  wel <= 1'b0;
               end
            end
            state    <= S_IDLE;
            bit_cnt  <= '0;
            spi_miso <= 1'b0;
            addr_hi  <= 1'b0;
            is_write <= 1'b0;
            wrote    <= 1'b0;
            wel_act  <= '0;
         end else if (cs_fall && state == S_IDLE) begin
            state   <= S_CMD;
            bit_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_resp.sv
// Self-checking bench for spi_flash_resp: frame-level flash model, per-cycle status/idle checks,
// directed scenarios with literal expectations, then randomized command frames.
module tb_spi_flash_resp;

   localparam int ADDR_W   = 8;
   localparam int PAGE_W   = 4;
   // Longer than one SPI byte so that busy status and busy rejection are observable over SPI.
   localparam int PROG_CYC = 800;
   localparam int H        = 6;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic spi_clk = 1'b0;
   logic spi_cs = 1'b1;
   logic spi_mosi = 1'b0;
   logic spi_miso, wip, wel, cmd_err;

   spi_flash_resp #(.ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .PROG_CYC(PROG_CYC)) dut (
      .clk      (clk),
      .reset    (reset),
      .spi_clk  (spi_clk),
      .spi_cs   (spi_cs),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .wip      (wip),
      .wel      (wel),
      .cmd_err  (cmd_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   logic [7:0] m_mem [256];
   logic       m_wel = 1'b0;
   int         wlo = 1;
   int         whi = 0;
   int         quiet_until = 0;
   int         err_seen = 0;
   int         run = 0;
   int         last_run = 0;
   logic [7:0] tx [16];
   logic [7:0] rx [16];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic in_wip(input int c);
      return (c >= wlo) && (c <= whi);
   endfunction

   function automatic logic near(input int c, input int x);
      return (c + 1 >= x) && (c <= x + 1);
   endfunction

   always @(negedge clk) begin
      if (reset && cyc >= quiet_until) begin
         check("wel", {31'b0, wel}, {31'b0, m_wel});
         if (!near(cyc, wlo) && !near(cyc, whi + 1))
            check("wip", {31'b0, wip}, {31'b0, in_wip(cyc)});
         if (spi_cs) check("miso_idle", {31'b0, spi_miso}, 32'd0);
      end
      if (cmd_err) err_seen++;
      if (wip) run++;
      else if (run != 0) begin
         last_run = run;
         run = 0;
      end
   end

   task automatic spi_bit(input logic b, output logic r);
      @(negedge clk) spi_mosi = b;
      repeat (H) @(negedge clk);
      spi_clk = 1'b1;
      r = spi_miso;
      repeat (H) @(negedge clk);
      spi_clk = 1'b0;
   endtask

   task automatic ld(input logic [7:0] b0, input logic [7:0] b1 = 0, input logic [7:0] b2 = 0,
                     input logic [7:0] b3 = 0, input logic [7:0] b4 = 0, input logic [7:0] b5 = 0,
                     input logic [7:0] b6 = 0);
      tx[0] = b0; tx[1] = b1; tx[2] = b2; tx[3] = b3; tx[4] = b4; tx[5] = b5; tx[6] = b6;
   endtask

   task automatic wait_wip;
      while (cyc <= whi + 4) @(negedge clk);
   endtask

   // Sends tx[0..n-1] plus xb trailing bits in one cs frame, then checks against the flash model.
   task automatic frame(input int n, input int xb);
      logic [7:0] exp_rx [16];
      logic       r, wipf, exp_err;
      logic [7:0] op, a;
      int         e0, cs_cyc;
      int         dur;
      dur = (n * 8 + xb) * (2 * H + 2) + 40;
      if (in_wip(cyc) != in_wip(cyc + dur)) wait_wip();
      wipf = in_wip(cyc);
      e0 = err_seen;
      @(negedge clk) spi_cs = 1'b0;
      repeat (H) @(negedge clk);
      for (int i = 0; i < n; i++)
         for (int b = 7; b >= 0; b--) begin
            spi_bit(tx[i][b], r);
            rx[i][b] = r;
         end
      for (int k = 0; k < xb; k++) spi_bit(1'($urandom), r);
      repeat (H) @(negedge clk);
      spi_cs = 1'b1;
      cs_cyc = cyc;
      quiet_until = cyc + 8;

      for (int i = 0; i < 16; i++) exp_rx[i] = 8'h00;
      exp_err = 1'b0;
      op = tx[0];
      if (n >= 1) begin
         if (op == 8'h05) begin
            for (int i = 1; i < n; i++) exp_rx[i] = {6'b0, m_wel, wipf};
         end else if (wipf) begin
            exp_err = 1'b1;
         end else begin
            case (op)
               8'h06: m_wel = 1'b1;
               8'h04: m_wel = 1'b0;
               8'h03: for (int i = 3; i < n; i++) begin
                  a = tx[2] + 8'(i - 3);
                  exp_rx[i] = m_mem[a];
               end
               8'h02: begin
                  if (!m_wel) exp_err = 1'b1;
                  else if (n >= 4) begin
                     for (int j = 0; j < n - 3; j++) begin
                        a = {tx[2][7:4], 4'(tx[2][3:0] + 4'(j))};
                        m_mem[a] = tx[3 + j];
                     end
                     m_wel = 1'b0;
                     wlo = cs_cyc + 3;
                     whi = cs_cyc + 2 + PROG_CYC;
                  end
               end
               default: exp_err = 1'b1;
            endcase
         end
      end

      repeat (10) @(negedge clk);
      check("cmd_err_pulses", 32'(err_seen - e0), {31'b0, exp_err});
      for (int i = 0; i < n; i++) check($sformatf("rx_byte%0d", i), {24'b0, rx[i]}, {24'b0, exp_rx[i]});
   endtask

   initial begin
      repeat (150000) @(posedge clk);
      fails++;
      $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      int r, n, xb;
      logic [7:0] op;
      for (int i = 0; i < 256; i++) m_mem[i] = 8'hFF;

      repeat (4) @(negedge clk);
      check("rst_miso", {31'b0, spi_miso}, 32'd0);
      check("rst_wip", {31'b0, wip}, 32'd0);
      check("rst_wel", {31'b0, wel}, 32'd0);
      check("rst_cmd_err", {31'b0, cmd_err}, 32'd0);
      reset = 1'b1;
      quiet_until = cyc + 2;
      repeat (4) @(negedge clk);

      // Status after reset, then with the write latch set
      ld(8'h05, 8'h00);             frame(2, 0); check("t1_rdsr0", {24'b0, rx[1]}, 32'h00);
      ld(8'h06);                    frame(1, 0);
      ld(8'h05, 8'h00, 8'h00);      frame(3, 0); check("t1_rdsr_wel", {24'b0, rx[2]}, 32'h02);

      // Program two bytes, busy status, busy length, read back
      ld(8'h02, 8'h00, 8'h10, 8'hA5, 8'h5A); frame(5, 0);
      ld(8'h05, 8'h00);             frame(2, 0); check("t2_rdsr_busy", {24'b0, rx[1]}, 32'h01);
      wait_wip();
      check("t2_wip_len", 32'(last_run), 32'(PROG_CYC));
      ld(8'h05, 8'h00);             frame(2, 0); check("t2_rdsr_done", {24'b0, rx[1]}, 32'h00);
      ld(8'h03, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00); frame(6, 0);
      check("t2_rd0", {24'b0, rx[3]}, 32'hA5);
      check("t2_rd1", {24'b0, rx[4]}, 32'h5A);
      check("t2_rd2", {24'b0, rx[5]}, 32'hFF);

      // Program without write enable is rejected
      r = err_seen;
      ld(8'h02, 8'h00, 8'h20, 8'h77); frame(4, 0);
      check("t3_err", 32'(err_seen - r), 32'd1);
      ld(8'h03, 8'h00, 8'h20, 8'h00); frame(4, 0); check("t3_rd", {24'b0, rx[3]}, 32'hFF);

      // Page wrap on program
      ld(8'h06); frame(1, 0);
      ld(8'h02, 8'h00, 8'h1E, 8'h11, 8'h22, 8'h33, 8'h44); frame(7, 0);
      wait_wip();
      ld(8'h03, 8'h00, 8'h1E, 8'h00, 8'h00); frame(5, 0);
      check("t4_1e", {24'b0, rx[3]}, 32'h11);
      check("t4_1f", {24'b0, rx[4]}, 32'h22);
      ld(8'h03, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00); frame(6, 0);
      check("t4_10", {24'b0, rx[3]}, 32'h33);
      check("t4_11", {24'b0, rx[4]}, 32'h44);
      check("t4_12", {24'b0, rx[5]}, 32'hFF);

      // Read address wrap and upper address bits ignored
      ld(8'h06); frame(1, 0);
      ld(8'h02, 8'h00, 8'hFF, 8'hC3); frame(4, 0); wait_wip();
      ld(8'h06); frame(1, 0);
      ld(8'h02, 8'h00, 8'h00, 8'h3C); frame(4, 0); wait_wip();
      ld(8'h03, 8'h00, 8'hFF, 8'h00, 8'h00); frame(5, 0);
      check("t5_ff", {24'b0, rx[3]}, 32'hC3);
      check("t5_00", {24'b0, rx[4]}, 32'h3C);
      ld(8'h03, 8'h12, 8'hFF, 8'h00, 8'h00); frame(5, 0);
      check("t5_alias_ff", {24'b0, rx[3]}, 32'hC3);
      check("t5_alias_00", {24'b0, rx[4]}, 32'h3C);

      // Partial data byte, unknown opcode, command while busy
      ld(8'h06); frame(1, 0);
      ld(8'h02, 8'h00, 8'h40); frame(3, 5);
      check("t6_wel_kept", {31'b0, wel}, 32'd1);
      check("t6_no_wip", {31'b0, wip}, 32'd0);
      ld(8'h03, 8'h00, 8'h40, 8'h00); frame(4, 0); check("t6_rd", {24'b0, rx[3]}, 32'hFF);
      r = err_seen;
      ld(8'h9F, 8'h00); frame(2, 0);
      check("t6_9f_err", 32'(err_seen - r), 32'd1);
      ld(8'h02, 8'h00, 8'h50, 8'h01); frame(4, 0);
      r = err_seen;
      ld(8'h03, 8'h00, 8'h50, 8'h00); frame(4, 0);
      check("t6_busy_err", 32'(err_seen - r), 32'd1);
      check("t6_busy_rx", {24'b0, rx[3]}, 32'h00);
      wait_wip();

      // Reset during busy: wip aborts, written data kept
      ld(8'h06); frame(1, 0);
      ld(8'h02, 8'h00, 8'h60, 8'hAB); frame(4, 0);
      repeat (20) @(negedge clk);
      reset = 1'b0;
      m_wel = 1'b0;
      wlo = 1;
      whi = 0;
      repeat (3) @(negedge clk);
      check("rst_mid_wip", {31'b0, wip}, 32'd0);
      check("rst_mid_wel", {31'b0, wel}, 32'd0);
      reset = 1'b1;
      quiet_until = cyc + 4;
      repeat (4) @(negedge clk);
      ld(8'h03, 8'h00, 8'h60, 8'h00); frame(4, 0); check("rst_mid_kept", {24'b0, rx[3]}, 32'hAB);

      // Randomized command frames
      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1:    op = 8'h05;
            2, 3:    op = 8'h06;
            4:       op = 8'h04;
            5, 6:    op = 8'h03;
            7, 8:    op = 8'h02;
            default: op = 8'($urandom);
         endcase
         if (op == 8'h03)      n = 3 + $urandom_range(0, 3);
         else if (op == 8'h02) n = 3 + $urandom_range(0, 4);
         else                  n = 1 + $urandom_range(0, 2);
         xb = (k % 7 == 3) ? $urandom_range(1, 7) : 0;
         tx[0] = op;
         for (int i = 1; i < 16; i++) tx[i] = 8'($urandom);
         frame(n, xb);
      end

      wait_wip();
      repeat (10) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
